instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage feeding the control unit and datapath. Holds the PC, fetches one word per
//   instruction from instruction memory over a req/ack handshake, and presents the captured
//   instruction with instr_valid. opcode (instr[31:26]) drives the control unit's 6-bit input.
//   Honours downstream stall and jump/branch redirects, including redirects that arrive
//   while a fetch is outstanding.
// PARAMETERS
//   ADDR_W    32     PC / memory address width
//   DATA_W    32     instruction width (opcode = bits DATA_W-1 : DATA_W-6)
//   RESET_PC  32'h0  PC value loaded on reset
//   PC_STEP   4      sequential PC increment (byte addressing)
// PORTS
//   clock           in   1       single clock, rising edge
//   reset_n         in   1       asynchronous, active-low reset
//   imem_req        out  1       fetch request, held until imem_ack
//   imem_addr       out  ADDR_W  fetch address, stable while imem_req=1
//   imem_rdata      in   DATA_W  instruction word, valid when imem_ack=1
//   imem_ack        in   1       1-cycle completion pulse; may come in the first req cycle
//   stall           in   1       downstream cannot accept; hold instr/pc_out
//   redirect_valid  in   1       1-cycle pulse: taken branch or jump
//   redirect_pc     in   ADDR_W  target PC, sampled when redirect_valid=1
//   instr_valid     out  1       instr/pc_out/opcode hold a live instruction
//   instr           out  DATA_W  captured instruction register
//   opcode          out  6       instr[DATA_W-1 -: 6], to control unit
//   pc_out          out  ADDR_W  PC of instr
//   pc_plus_step    out  ADDR_W  pc_out + PC_STEP (link / branch base)
// BEHAVIOUR
//   Reset (async on reset_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//     instr=0, opcode=0, instr_valid=0, pc_out=RESET_PC, pc_plus_step=RESET_PC+PC_STEP,
//     redir_pend=0. Asserting reset mid-transaction abandons it; no ack tracking survives.
//   FSM (registered, 3 states):
//     IDLE  -> REQ on first edge after reset_n=1. imem_req=0. redirect_valid ignored.
//     REQ   imem_req=1, imem_addr=pc. On imem_ack:
//             redir_pend=0 and no redirect this cycle: instr<=imem_rdata, pc_out<=pc,
//               instr_valid<=1 -> VALID.
//             redir_pend=1 or redirect_valid this cycle: discard rdata, pc<=target,
//               redir_pend<=0, stay REQ (new request next cycle, instr_valid stays 0).
//           No ack + redirect_valid: redir_pend<=1, redir_pc<=redirect_pc; imem_addr
//           must NOT change until ack. A later redirect before ack overwrites redir_pc.
//     VALID instr_valid=1, imem_req=0.
//           redirect_valid (priority over stall): pc<=redirect_pc, instr_valid<=0 -> REQ.
//           stall=1: hold all outputs, stay VALID.
//           else: pc<=pc+PC_STEP, instr_valid<=0 -> REQ.
//   Latency: ack in first REQ cycle -> instr_valid next edge; best throughput 1 instr/2 cycles.
//   PC arithmetic modulo 2^ADDR_W; pc+PC_STEP wraps silently at max address.
//   Misaligned redirect_pc is passed through unmodified (no exception).
//   imem_ack outside REQ is ignored. Opcodes unknown to control are fetched normally.
// STRUCTURE
//   mips_pkg: state enum {IDLE,REQ,VALID}; opcode constants OP_RTYPE 6'b000000,
//     OP_ITYPE 6'b000001, OP_LW 6'b100010, OP_LI 6'b100011, OP_SW 6'b101010,
//     OP_BEQ 6'b000100, OP_BNE 6'b000110, OP_J 6'b010000; default RESET_PC.
//   One sub-module: pc_register (pc, redir_pend/redir_pc, next-PC mux); FSM and
//   instruction register stay in instruction_fetch.
// TESTING
//   1 Reset, release; mem acks in first REQ cycle with 32'h0000_0000 then 32'h1000_0000 ->
//     imem_addr 0 then 4; instr_valid 1 per 2 cycles; opcode 000000 then 000100.
//   2 Ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr constant 0, single capture.
//   3 stall=1 for 5 cycles in VALID -> instr, pc_out, instr_valid unchanged; no imem_req;
//     release -> next fetch at pc_out+4.
//   4 redirect_valid with redirect_pc=32'h40 in VALID while stall=1 -> instr_valid 0 next
//     cycle, next imem_addr 32'h40.
//   5 redirect 32'h80 during outstanding fetch of 32'h8 (ack 2 cycles later) -> addr stays 8
//     until ack, data discarded, instr_valid stays 0, next request addr 32'h80.
//   6 reset_n pulsed low mid-REQ -> all outputs at reset values immediately; late ack ignored;
//     fetch restarts at RESET_PC. Also pc=32'hFFFF_FFFC advance -> next addr 32'h0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style front end.
// Holds the fetch FSM state encoding, the opcodes the control unit decodes and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } if_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ITYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b100010;
    localparam logic [5:0] OP_LI    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000110;
    localparam logic [5:0] OP_J     = 6'b010000;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter plus the parked redirect target for redirects that land while a fetch is in flight.
// The fetch address is simply pc_o, so it cannot move until the outstanding request is acknowledged.
module instruction_fetch_pc_register
    import mips_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              in_req_i,
    input  logic              in_valid_i,
    input  logic              ack_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              discard_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic              redir_pend_q, redir_pend_d;

    always_comb begin
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        if (in_req_i) begin
            if (ack_i) begin
                redir_pend_d = 1'b0;
                // A redirect in the ack cycle is newer than any parked one.
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end else if (redir_pend_q) begin
                    pc_d = redir_pc_q;
                end
            end else if (redirect_valid_i) begin
                redir_pend_d = 1'b1;
                redir_pc_d   = redirect_pc_i;
            end
        end else if (in_valid_i) begin
            if (redirect_valid_i) begin
                pc_d = redirect_pc_i;
            end else if (!stall_i) begin
                pc_d = pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q         <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    assign pc_o      = pc_q;
    assign discard_o = in_req_i && ack_i && (redir_pend_q || redirect_valid_i);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: IDLE/REQ/VALID handshake FSM and the instruction register.
// Redirect bookkeeping lives in the PC sub-module; this level decides when a word is kept.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = 4
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              imem_ack_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [5:0]        opcode_o,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic [ADDR_W-1:0] pc_plus_step_o
);

    if_state_e         state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] pc;
    logic              discard;

    instruction_fetch_pc_register #(
        .ADDR_W   (ADDR_W),
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock_i          (clock_i),
        .reset_n_i        (reset_n_i),
        .in_req_i         (state_q == REQ),
        .in_valid_i       (state_q == VALID),
        .ack_i            (imem_ack_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc),
        .discard_o        (discard)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack_i && !discard) begin
                    instr_d  = imem_rdata_i;
                    pc_out_d = pc;
                    state_d  = VALID;
                end
            end
            VALID: begin
                if (redirect_valid_i || !stall_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req_o     = (state_q == REQ);
    assign imem_addr_o    = pc;
    assign instr_valid_o  = (state_q == VALID);
    assign instr_o        = instr_q;
    assign opcode_o       = instr_q[DATA_W-1 -: 6];
    assign pc_out_o       = pc_out_q;
    assign pc_plus_step_o = pc_out_q + ADDR_W'(PC_STEP);

endmodule
